// File: rtl/fetch_stage_if.sv
// Instruction-fetch bus bundle: instruction-memory handshake, hazard
// controls from the pipeline, and the IF/ID register outputs.
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        stall_IFID;
    logic        flush_IFID;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr_out;
    logic [31:0] npc_out;
    logic        valid_out;

    // Fetch-stage side of the bundle.
    modport master (
        input  ihit, imemload, stall_IFID, flush_IFID, redirect_pc, halt,
        output iREN, imemaddr, instr_out, npc_out, valid_out
    );

    // Environment side: memory and pipeline control.
    modport slave (
        output ihit, imemload, stall_IFID, flush_IFID, redirect_pc, halt,
        input  iREN, imemaddr, instr_out, npc_out, valid_out
    );
endinterface

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: owns the PC, issues instruction reads and fills the
// IF/ID register. A redirect that arrives while a read is outstanding parks
// its target in pend_pc; the stale word is dropped when it returns.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_pc_q;
    logic [31:0] instr_q;
    logic [31:0] npc_q;
    logic        valid_q;
    logic        iren_q;

    logic [31:0] pc_inc_d;
    logic        advance_d;

    // Sequential PC increment, wraps naturally at 2^32.
    assign pc_inc_d  = pc_q + 32'd4;
    assign advance_d = (state_q == FETCH) & bus.ihit & ~bus.stall_IFID
                       & ~bus.flush_IFID & ~bus.halt;

    // Fetch FSM: priority is reset, halted, halt, flush, then normal flow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= FETCH;
            pc_q      <= PC_INIT;
            pend_pc_q <= 32'h0;
            instr_q   <= 32'h0;
            npc_q     <= 32'h0;
            valid_q   <= 1'b0;
            iren_q    <= 1'b1;
        end else begin
            case (state_q)
                HALTED: begin
                    // Sticky until reset; IF/ID already holds a bubble.
                end
                FETCH, DISCARD: begin
                    if (bus.halt) begin
                        state_q <= HALTED;
                        iren_q  <= 1'b0;
                        instr_q <= 32'h0;
                        npc_q   <= 32'h0;
                        valid_q <= 1'b0;
                    end else if (bus.flush_IFID) begin
                        instr_q <= 32'h0;
                        npc_q   <= 32'h0;
                        valid_q <= 1'b0;
                        if (bus.ihit) begin
                            pc_q    <= bus.redirect_pc;
                            state_q <= FETCH;
                        end else begin
                            // Read still in flight: keep the address stable
                            // and remember where to go once it lands.
                            pend_pc_q <= bus.redirect_pc;
                            state_q   <= DISCARD;
                        end
                    end else if (state_q == DISCARD) begin
                        if (bus.ihit) begin
                            pc_q    <= pend_pc_q;
                            state_q <= FETCH;
                        end
                    end else if (advance_d) begin
                        instr_q <= bus.imemload;
                        npc_q   <= pc_inc_d;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc_d;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign bus.iREN      = iren_q;
    assign bus.imemaddr  = pc_q;
    assign bus.instr_out = instr_q;
    assign bus.npc_out   = npc_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] PC_INIT = 32'h00000000;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    fetch_stage_if bus ();

    fetch_stage #(.PC_INIT(PC_INIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_halted;
    bit          m_waiting;   // redirect pending behind an outstanding read
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    bit          m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_npc   = 32'h0;
        m_valid = 1'b0;
    endtask

    // Apply the fetch rules for one rising edge.
    task automatic model_edge(input logic r, input logic h, input logic [31:0] ld,
                              input logic st, input logic fl, input logic [31:0] rp,
                              input logic hl);
        if (r) begin
            m_pc = PC_INIT; m_pend = 32'h0; m_halted = 0; m_waiting = 0;
            model_bubble();
        end else if (m_halted) begin
            // inputs ignored
        end else if (hl) begin
            m_halted = 1;
            model_bubble();
        end else if (fl) begin
            model_bubble();
            if (h) begin
                m_pc = rp; m_waiting = 0;
            end else begin
                m_pend = rp; m_waiting = 1;
            end
        end else if (m_waiting) begin
            if (h) begin
                m_pc = m_pend; m_waiting = 0;
            end
        end else if (h && !st) begin
            m_instr = ld;
            m_npc   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".iREN"},      {31'h0, bus.iREN},      {31'h0, !m_halted});
        check({tag, ".imemaddr"},  bus.imemaddr,           m_pc);
        check({tag, ".instr_out"}, bus.instr_out,          m_instr);
        check({tag, ".npc_out"},   bus.npc_out,            m_npc);
        check({tag, ".valid_out"}, {31'h0, bus.valid_out}, {31'h0, m_valid});
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1ns later.
    task automatic step(input string tag, input logic r, input logic h, input logic [31:0] ld,
                        input logic st, input logic fl, input logic [31:0] rp, input logic hl);
        RST             = r;
        bus.ihit        = h;
        bus.imemload    = ld;
        bus.stall_IFID  = st;
        bus.flush_IFID  = fl;
        bus.redirect_pc = rp;
        bus.halt        = hl;
        @(posedge CLK);
        model_edge(r, h, ld, st, fl, rp, hl);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [31:0] prev_addr;
        logic        prev_ren;
        logic        r, h, st, fl, hl;
        logic [31:0] ld, rp;

        checks = 0;
        errors = 0;
        m_pc = 32'h0; m_pend = 32'h0; m_halted = 0; m_waiting = 0;
        model_bubble();

        // Reset state and first fetch address.
        step("rst0", 1, 0, 32'h0, 0, 0, 32'h0, 0);
        step("rst1", 1, 1, 32'hFFFF_FFFF, 1, 1, 32'h0000_0700, 1);
        check("rst.valid", {31'h0, bus.valid_out}, 32'h0);
        check("rst.iREN",  {31'h0, bus.iREN},      32'h1);
        check("rst.addr",  bus.imemaddr,           PC_INIT);

        // Back-to-back hits.
        step("hit1", 0, 1, 32'h2001_0005, 0, 0, 32'h0, 0);
        check("hit1.instr", bus.instr_out, 32'h2001_0005);
        check("hit1.npc",   bus.npc_out,   32'h0000_0004);
        check("hit1.valid", {31'h0, bus.valid_out}, 32'h1);
        step("hit2", 0, 1, 32'h2001_0005, 0, 0, 32'h0, 0);
        check("hit2.pc", bus.imemaddr, 32'h0000_0008);

        // Miss for three cycles at 0x10, then hit.
        step("redir10", 0, 1, 32'h0, 0, 1, 32'h0000_0010, 0);
        for (int i = 0; i < 3; i++) begin
            step("miss", 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0, 0);
            check("miss.addr", bus.imemaddr, 32'h0000_0010);
        end
        step("misshit", 0, 1, 32'h1111_1111, 0, 0, 32'h0, 0);
        check("misshit.instr", bus.instr_out, 32'h1111_1111);
        check("misshit.npc",   bus.npc_out,   32'h0000_0014);

        // Stall with hits at 0x10.
        step("redir10b", 0, 1, 32'h0, 0, 1, 32'h0000_0010, 0);
        for (int i = 0; i < 2; i++) begin
            step("stall", 0, 1, 32'h2222_2222, 1, 0, 32'h0, 0);
            check("stall.addr", bus.imemaddr, 32'h0000_0010);
        end
        step("unstall", 0, 1, 32'h2222_2222, 0, 0, 32'h0, 0);
        check("unstall.pc", bus.imemaddr, 32'h0000_0014);

        // Flush during an outstanding miss.
        step("redir20", 0, 1, 32'h0, 0, 1, 32'h0000_0020, 0);
        step("flmiss", 0, 0, 32'h0, 0, 1, 32'h0000_0100, 0);
        check("flmiss.addr",  bus.imemaddr, 32'h0000_0020);
        check("flmiss.valid", {31'h0, bus.valid_out}, 32'h0);
        step("discard", 0, 1, 32'h3333_3333, 0, 0, 32'h0, 0);
        check("discard.pc",    bus.imemaddr, 32'h0000_0100);
        check("discard.valid", {31'h0, bus.valid_out}, 32'h0);
        step("after", 0, 1, 32'h4444_4444, 0, 0, 32'h0, 0);
        check("after.instr", bus.instr_out, 32'h4444_4444);
        check("after.npc",   bus.npc_out,   32'h0000_0104);

        // Second flush while discarding: newest target wins.
        step("dfl1", 0, 0, 32'h0, 0, 1, 32'h0000_0100, 0);
        step("dfl2", 0, 0, 32'h0, 1, 1, 32'h0000_0200, 0);
        step("dhit", 0, 1, 32'h5555_5555, 0, 0, 32'h0, 0);
        check("dhit.pc", bus.imemaddr, 32'h0000_0200);

        // PC wrap and unaligned redirect pass-through.
        step("redirtop", 0, 1, 32'h0, 0, 1, 32'hFFFF_FFFC, 0);
        step("wrap", 0, 1, 32'h6666_6666, 0, 0, 32'h0, 0);
        check("wrap.npc", bus.npc_out,  32'h0000_0000);
        check("wrap.pc",  bus.imemaddr, 32'h0000_0000);
        step("unal", 0, 1, 32'h0, 0, 1, 32'h0000_0103, 0);
        check("unal.pc", bus.imemaddr, 32'h0000_0103);
        step("unalhit", 0, 1, 32'h7777_7777, 0, 0, 32'h0, 0);
        check("unalhit.npc", bus.npc_out, 32'h0000_0107);

        // Flush beats stall.
        step("flst", 0, 1, 32'h0, 1, 1, 32'h0000_0040, 0);
        check("flst.pc", bus.imemaddr, 32'h0000_0040);

        // Halt beats flush; halted ignores everything until reset.
        step("halt", 0, 1, 32'h8888_8888, 0, 1, 32'h0000_0500, 1);
        check("halt.iREN",  {31'h0, bus.iREN}, 32'h0);
        check("halt.pc",    bus.imemaddr, 32'h0000_0040);
        check("halt.valid", {31'h0, bus.valid_out}, 32'h0);
        for (int i = 0; i < 4; i++)
            step("halted", 0, 1, $urandom, 0, i[0], 32'h0000_0600, 0);
        check("halted.pc", bus.imemaddr, 32'h0000_0040);
        step("hrst", 1, 0, 32'h0, 0, 0, 32'h0, 0);
        check("hrst.pc",   bus.imemaddr, PC_INIT);
        check("hrst.iREN", {31'h0, bus.iREN}, 32'h1);

        // Halt and reset while discarding.
        step("dsc", 0, 0, 32'h0, 0, 1, 32'h0000_0300, 0);
        step("dschalt", 0, 0, 32'h0, 0, 0, 32'h0, 1);
        check("dschalt.iREN", {31'h0, bus.iREN}, 32'h0);
        step("rst2", 1, 0, 32'h0, 0, 0, 32'h0, 0);
        step("dsc2", 0, 0, 32'h0, 0, 1, 32'h0000_0300, 0);
        step("dscrst", 1, 1, 32'h0, 0, 0, 32'h0, 0);
        check("dscrst.pc", bus.imemaddr, PC_INIT);
        step("postrst", 0, 1, 32'h9999_9999, 0, 0, 32'h0, 0);
        check("postrst.npc", bus.npc_out, PC_INIT + 32'd4);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            prev_addr = bus.imemaddr;
            prev_ren  = bus.iREN;
            r  = ($urandom_range(0, 39) == 0);
            h  = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 5) == 0);
            hl = ($urandom_range(0, 47) == 0);
            ld = $urandom;
            rp = $urandom;
            step("rand", r, h, ld, st, fl, rp, hl);
            if (!r && prev_ren && !h)
                check("rand.addrstable", bus.imemaddr, prev_addr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
